// File: rtl/basys3_ui_pkg.sv
// Shared types and constants for the Basys 3 push-button front end.
package basys3_ui_pkg;

  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    HELD            = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } btn_state_t;

  // Bit positions inside the {BTNU, BTND, BTNL, BTNR, BTNC} vector.
  localparam int BTN_C = 0;
  localparam int BTN_R = 1;
  localparam int BTN_L = 2;
  localparam int BTN_D = 3;
  localparam int BTN_U = 4;

  localparam int DEF_NUM_BTN         = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 2_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: two-flop synchronizer, confirm/held debounce FSM, edge pulses and,
// when BTN_AUTOREPEAT_EN is defined, a hold-to-repeat timer.
module btn_debounce_cell
  import basys3_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       btn_repeat,
  output btn_state_t state_dbg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync1, sync2;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          level_d, press_d, release_d;

  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
    end
  end

  // cnt holds the number of consecutive confirming samples already seen.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sync2) begin
          state_d = CONFIRM_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      CONFIRM_PRESS: begin
        if (!sync2) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!sync2) begin
          state_d = CONFIRM_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      CONFIRM_RELEASE: begin
        if (sync2) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    press_d   = (state_q == CONFIRM_PRESS) && (state_d == HELD);
    release_d = (state_q == CONFIRM_RELEASE) && (state_d == IDLE);
    level_d   = (state_d == HELD) || (state_d == CONFIRM_RELEASE);
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RW-1:0] rep_cnt;
  logic          holding, rep_fire;

  // Bounces in CONFIRM_RELEASE keep the timer running; only acceptance stops it.
  assign holding  = (state_q == HELD) || (state_q == CONFIRM_RELEASE);
  assign rep_fire = holding && !release_d && (rep_cnt == REP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt    <= '0;
      btn_repeat <= 1'b0;
    end else begin
      if (press_d || !holding) begin
        rep_cnt <= '0;
      end else if (rep_cnt == REP_LAST) begin
        rep_cnt <= REP_RELOAD;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
      btn_repeat <= rep_fire;
    end
  end
`else
  assign btn_repeat = 1'b0;
`endif

endmodule

// File: rtl/basys3_button_conditioner.sv
// Basys 3 push-button conditioner: one independent debounce cell per button.
// Define BTN_AUTOREPEAT_EN to build the hold-to-repeat timers.
module basys3_button_conditioner
  import basys3_ui_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BTN-1:0]   btn_raw,
  output logic [NUM_BTN-1:0]   btn_level,
  output logic [NUM_BTN-1:0]   btn_press,
  output logic [NUM_BTN-1:0]   btn_release,
  output logic [NUM_BTN-1:0]   btn_repeat,
  output logic                 btn_any_press,
  output logic [2*NUM_BTN-1:0] btn_state_dbg
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .raw        (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_repeat (btn_repeat[i]),
      .state_dbg  (btn_state_dbg[2*i +: 2])
    );
  end

  // OR of registered pulses, so it is aligned with btn_press.
  assign btn_any_press = |btn_press;

endmodule

// File: tb/tb_basys3_button_conditioner.sv
// Directed bench for basys3_button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3; repeat expectations follow BTN_AUTOREPEAT_EN.
module tb_basys3_button_conditioner;
  import basys3_ui_pkg::*;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_raw;
  logic [4:0] btn_level, btn_press, btn_release, btn_repeat;
  logic       btn_any_press;
  logic [9:0] btn_state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  basys3_button_conditioner #(
    .NUM_BTN        (5),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .btn_repeat   (btn_repeat),
    .btn_any_press(btn_any_press),
    .btn_state_dbg(btn_state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Repeat pulses land at press+10, then every 3 cycles, up to 'last'.
  function automatic logic rep_exp(input int k, input int last);
    return REP_ON && (k >= 10) && (k <= last) && (((k - 10) % 3) == 0);
  endfunction

  task automatic release_all();
    btn_raw = 5'b0;
    for (int i = 0; i < 8; i++) step();
  endtask

  initial begin
    rst     = 1'b1;
    btn_raw = 5'b0;
    for (int i = 0; i < 3; i++) step();
    check("reset_level",   32'(btn_level), 32'h0);
    check("reset_press",   32'(btn_press), 32'h0);
    check("reset_release", 32'(btn_release), 32'h0);
    check("reset_repeat",  32'(btn_repeat), 32'h0);
    check("reset_any",     32'(btn_any_press), 32'h0);
    check("reset_state",   32'(btn_state_dbg), 32'h0);
    rst = 1'b0;
    step();

    // Clean BTNC press: first sampled at edge 0, press pulse after edge 5.
    btn_raw[BTN_C] = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      step();
      check("t1_press", 32'(btn_press), (e == 5) ? 32'h01 : 32'h0);
      check("t1_level", 32'(btn_level), (e == 5) ? 32'h01 : 32'h0);
      check("t1_any",   32'(btn_any_press), (e == 5) ? 32'h1 : 32'h0);
    end
    // Hold, then release: raw drops before press+27, release at press+32.
    for (int k = 1; k <= 32; k++) begin
      if (k == 27) btn_raw[BTN_C] = 1'b0;
      step();
      check("t1_repeat",  32'(btn_repeat), rep_exp(k, 31) ? 32'h01 : 32'h0);
      check("t1_hpress",  32'(btn_press), 32'h0);
      check("t1_release", 32'(btn_release), (k == 32) ? 32'h01 : 32'h0);
      check("t1_hlevel",  32'(btn_level), (k < 32) ? 32'h01 : 32'h0);
    end
    step();
    check("t1_rel_once", 32'(btn_release), 32'h0);
    check("t1_idle",     32'(btn_state_dbg), 32'h0);

    // BTNL bounce: 1,1,0,0,1,1,0,0 then held; only the last rise is accepted.
    for (int e = 0; e <= 15; e++) begin
      btn_raw[BTN_L] = (e < 8) ? ((e % 4) < 2) : 1'b1;
      step();
      check("t2_press",   32'(btn_press), (e == 13) ? 32'h04 : 32'h0);
      check("t2_level",   32'(btn_level), (e >= 13) ? 32'h04 : 32'h0);
      check("t2_release", 32'(btn_release), 32'h0);
    end
    release_all();

    // BTNU: short drop is ignored and does not restart repeat, then real release.
    btn_raw[BTN_U] = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      step();
      check("t3_press", 32'(btn_press), (e == 5) ? 32'h10 : 32'h0);
    end
    for (int k = 1; k <= 20; k++) begin
      btn_raw[BTN_U] = (k >= 3) && (k <= 14);
      step();
      check("t3_release", 32'(btn_release), (k == 20) ? 32'h10 : 32'h0);
      check("t3_level",   32'(btn_level), (k < 20) ? 32'h10 : 32'h0);
      check("t3_repeat",  32'(btn_repeat), rep_exp(k, 19) ? 32'h10 : 32'h0);
      check("t3_hpress",  32'(btn_press), 32'h0);
    end
    release_all();

    // BTNR and BTND rise together.
    btn_raw = 5'b01010;
    for (int e = 0; e <= 6; e++) begin
      step();
      check("t4_press", 32'(btn_press), (e == 5) ? 32'h0A : 32'h0);
      check("t4_any",   32'(btn_any_press), (e == 5) ? 32'h1 : 32'h0);
      check("t4_level", 32'(btn_level), (e >= 5) ? 32'h0A : 32'h0);
    end
    release_all();

    // Reset while BTNR is held and BTNC is confirming.
    btn_raw = 5'b00010;
    for (int e = 0; e <= 6; e++) step();
    check("t6_pre_level", 32'(btn_level), 32'h02);
    btn_raw = 5'b00011;
    for (int e = 0; e <= 3; e++) step();
    check("t6_confirm", 32'(btn_state_dbg), 32'h009);
    rst = 1'b1;
    step();
    check("t6_rst_level",   32'(btn_level), 32'h0);
    check("t6_rst_press",   32'(btn_press), 32'h0);
    check("t6_rst_release", 32'(btn_release), 32'h0);
    check("t6_rst_state",   32'(btn_state_dbg), 32'h0);
    rst = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      step();
      check("t6_press",   32'(btn_press), (e == 5) ? 32'h03 : 32'h0);
      check("t6_level",   32'(btn_level), (e >= 5) ? 32'h03 : 32'h0);
      check("t6_release", 32'(btn_release), 32'h0);
    end
    release_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
